c0_sram_port_arbiter: RTL and testbench

//  Shares the single read/write port (port 0) of one sky130 1 KB SRAM macro (32x256) between two masters:
//  m0 (core load/store) and m1 (UART loader / debug).

---
 rtl/c0_sram_arb_pkg.sv | 21 ++
 rtl/c0_sram_port_arbiter_rr.sv | 68 ++++++
 rtl/c0_sram_port_arbiter.sv | 108 ++++++++++
 tb/tb_c0_sram_port_arbiter.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/c0_sram_arb_pkg.sv
// Shared types for the SRAM port-0 arbiter: owner encoding, pipeline-stage record, default widths.
// Latency: n/a (types only).
// Backpressure: n/a.
package c0_sram_arb_pkg;

  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 32;

  typedef enum logic {
    OWN_M0 = 1'b0,
    OWN_M1 = 1'b1
  } owner_e;

  // One in-flight access as it moves towards the response stage.
  typedef struct packed {
    logic   vld;
    logic   we;
    owner_e owner;
  } stage_t;

endpackage

// File: rtl/c0_sram_port_arbiter_rr.sv
// Two-way round-robin arbiter with an optional burst lock (C0_SRAM_ARB_LOCK_EN).
// Latency: grant is combinational from req in the same cycle; pointer/lock state update on the accept edge.
// Backpressure: a requester that loses a tie sees gnt=0 and must hold its request.
// Ports: clk/rst_n (async active-low); req[1:0], lock[1:0] per master; gnt[1:0] one-hot or zero.
module c0_rr_arb2
  import c0_sram_arb_pkg::*;
#(
  parameter int LOCK_MAX = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic [1:0] lock,
  output logic [1:0] gnt
);

  owner_e last_q;
  logic   last_m1;
  logic   tie_m1;

  assign last_m1 = (last_q == OWN_M1);

`ifdef C0_SRAM_ARB_LOCK_EN
  localparam int CW = $clog2(LOCK_MAX + 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          hold;

  // The most recent grantee is always the lock holder while the count is
  // non-zero, so the pointer doubles as the lock owner.
  assign hold   = (cnt_q != '0) && (cnt_q < CW'(LOCK_MAX)) && req[last_m1] && lock[last_m1];
  assign tie_m1 = hold ? last_m1 : ~last_m1;

  always_comb begin
    cnt_d = '0;
    if ((|gnt) && lock[gnt[1]]) begin
      // A new owner, or an owner restarting after a forced release, opens a fresh burst.
      if ((gnt[1] != last_m1) || (cnt_q == CW'(LOCK_MAX))) cnt_d = CW'(1);
      else                                                  cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
`else
  logic unused_lock;
  assign unused_lock = ^lock;
  assign tie_m1      = ~last_m1;
`endif

  always_comb begin
    gnt = 2'b00;
    if (rst_n) begin
      if (req == 2'b11) gnt = tie_m1 ? 2'b10 : 2'b01;
      else              gnt = req;
    end
  end

  // Pointer resets to m1 so that m0 takes the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    last_q <= OWN_M1;
    else if (|gnt) last_q <= gnt[1] ? OWN_M1 : OWN_M0;
  end

endmodule

// File: rtl/c0_sram_port_arbiter.sv
// Shares SRAM port 0 between m0 (core) and m1 (loader/debug); optional burst lock via C0_SRAM_ARB_LOCK_EN.
// Latency: accept in N, macro pins in N+1, read data/rvalid in N+2; one access per cycle.
// Backpressure: combinational gnt per master; a master holds req and fields until granted.
// Ports: clk_g, rst_g (async active-low); m0_*/m1_* req/we/wmask/addr/wdata/lock in, gnt/rvalid/rdata out;
//        sram_csb0/web0/wmask0/addr0/din0 registered macro pins, sram_dout0 macro read data.
module c0_sram_port_arbiter
  import c0_sram_arb_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int LOCK_MAX = 4
) (
  input  logic                clk_g,
  input  logic                rst_g,
  input  logic                m0_req,
  input  logic                m0_we,
  input  logic [DATA_W/8-1:0] m0_wmask,
  input  logic [ADDR_W-1:0]   m0_addr,
  input  logic [DATA_W-1:0]   m0_wdata,
  input  logic                m0_lock,
  output logic                m0_gnt,
  output logic                m0_rvalid,
  output logic [DATA_W-1:0]   m0_rdata,
  input  logic                m1_req,
  input  logic                m1_we,
  input  logic [DATA_W/8-1:0] m1_wmask,
  input  logic [ADDR_W-1:0]   m1_addr,
  input  logic [DATA_W-1:0]   m1_wdata,
  input  logic                m1_lock,
  output logic                m1_gnt,
  output logic                m1_rvalid,
  output logic [DATA_W-1:0]   m1_rdata,
  output logic                sram_csb0,
  output logic                sram_web0,
  output logic [DATA_W/8-1:0] sram_wmask0,
  output logic [ADDR_W-1:0]   sram_addr0,
  output logic [DATA_W-1:0]   sram_din0,
  input  logic [DATA_W-1:0]   sram_dout0
);

  localparam int MW = DATA_W / 8;

  logic [1:0]        gnt;
  logic              xfer;
  logic              sel_m1;
  logic              sel_we;
  logic [MW-1:0]     sel_wmask;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  stage_t            s1_q;
  stage_t            s2_q;
  logic              rd_rsp;

  c0_rr_arb2 #(.LOCK_MAX(LOCK_MAX)) u_arb (
    .clk   (clk_g),
    .rst_n (rst_g),
    .req   ({m1_req, m0_req}),
    .lock  ({m1_lock, m0_lock}),
    .gnt   (gnt)
  );

  assign m0_gnt = gnt[0];
  assign m1_gnt = gnt[1];

  assign xfer      = |gnt;
  assign sel_m1    = gnt[1];
  assign sel_we    = sel_m1 ? m1_we    : m0_we;
  assign sel_wmask = sel_m1 ? m1_wmask : m0_wmask;
  assign sel_addr  = sel_m1 ? m1_addr  : m0_addr;
  assign sel_wdata = sel_m1 ? m1_wdata : m0_wdata;

  // Macro pins; address/data/mask hold across idle cycles.
  always_ff @(posedge clk_g or negedge rst_g) begin
    if (!rst_g) begin
      sram_csb0   <= 1'b1;
      sram_web0   <= 1'b1;
      sram_wmask0 <= '0;
      sram_addr0  <= '0;
      sram_din0   <= '0;
    end else begin
      sram_csb0 <= ~xfer;
      sram_web0 <= ~(xfer & sel_we);
      if (xfer) begin
        sram_addr0  <= sel_addr;
        sram_din0   <= sel_wdata;
        sram_wmask0 <= sel_we ? sel_wmask : '0;
      end
    end
  end

  // s1 tracks the access on the pins, s2 the cycle its read data appears on dout.
  always_ff @(posedge clk_g or negedge rst_g) begin
    if (!rst_g) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= '{vld: xfer, we: sel_we, owner: owner_e'(sel_m1)};
      s2_q <= s1_q;
    end
  end

  assign rd_rsp    = s2_q.vld & ~s2_q.we;
  assign m0_rvalid = rd_rsp & (s2_q.owner == OWN_M0);
  assign m1_rvalid = rd_rsp & (s2_q.owner == OWN_M1);
  assign m0_rdata  = m0_rvalid ? sram_dout0 : '0;
  assign m1_rdata  = m1_rvalid ? sram_dout0 : '0;

endmodule

// File: tb/tb_c0_sram_port_arbiter.sv
// Bench for c0_sram_port_arbiter: behavioural SRAM, reference memory/arbitration model, directed vectors.
// Latency: n/a.
// Backpressure: n/a.
module tb_c0_sram_port_arbiter;

  logic        clk_g = 1'b0;
  logic        rst_g;
  logic        m0_req, m0_we, m0_lock, m1_req, m1_we, m1_lock;
  logic [3:0]  m0_wmask, m1_wmask;
  logic [7:0]  m0_addr, m1_addr;
  logic [31:0] m0_wdata, m1_wdata;
  logic        m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
  logic [31:0] m0_rdata, m1_rdata;
  logic        sram_csb0, sram_web0;
  logic [3:0]  sram_wmask0;
  logic [7:0]  sram_addr0;
  logic [31:0] sram_din0;
  logic [31:0] sram_dout0;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk_g = ~clk_g;

  c0_sram_port_arbiter dut (
    .clk_g(clk_g), .rst_g(rst_g),
    .m0_req(m0_req), .m0_we(m0_we), .m0_wmask(m0_wmask), .m0_addr(m0_addr),
    .m0_wdata(m0_wdata), .m0_lock(m0_lock), .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid),
    .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_wmask(m1_wmask), .m1_addr(m1_addr),
    .m1_wdata(m1_wdata), .m1_lock(m1_lock), .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid),
    .m1_rdata(m1_rdata),
    .sram_csb0(sram_csb0), .sram_web0(sram_web0), .sram_wmask0(sram_wmask0),
    .sram_addr0(sram_addr0), .sram_din0(sram_din0), .sram_dout0(sram_dout0)
  );

  // Behavioural macro: pins sampled on the clock, read data one cycle later.
  logic [31:0] sram_mem [256];
  initial begin
    for (int i = 0; i < 256; i++) sram_mem[i] = 32'h0;
    sram_dout0 = 32'h0;
  end
  always @(posedge clk_g) begin
    if (!sram_csb0) begin
      if (!sram_web0) begin
        for (int b = 0; b < 4; b++)
          if (sram_wmask0[b]) sram_mem[sram_addr0][8*b +: 8] <= sram_din0[8*b +: 8];
      end else begin
        sram_dout0 <= sram_mem[sram_addr0];
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [31:0] ref_mem [256];
  initial for (int i = 0; i < 256; i++) ref_mem[i] = 32'h0;

  bit          m_last_m1;              // master granted most recently
  int          m_run;                  // consecutive locked grants of m_last_m1
  bit          e_csb, e_web;
  logic [3:0]  e_wmask;
  logic [7:0]  e_addr;
  logic [31:0] e_din;
  bit          due_now_vld, due_nxt_vld;
  bit          due_now_m1, due_nxt_m1;
  logic [31:0] due_now_dat, due_nxt_dat;

  always @(negedge clk_g) begin
    bit          eg0, eg1, w1, hold;
    bit          g_we;
    logic [3:0]  g_mask;
    logic [7:0]  g_addr;
    logic [31:0] g_wd;
    if (!rst_g) begin
      check("rst_gnt",    {m0_gnt, m1_gnt}, 2'b00);
      check("rst_rvalid", {m0_rvalid, m1_rvalid}, 2'b00);
      check("rst_rdata",  {m0_rdata, m1_rdata}, 64'h0);
      check("rst_pins",   {sram_csb0, sram_web0, sram_wmask0, sram_addr0, sram_din0},
                          {1'b1, 1'b1, 4'h0, 8'h0, 32'h0});
      m_last_m1 = 1'b1; m_run = 0;
      e_csb = 1'b1; e_web = 1'b1; e_wmask = 4'h0; e_addr = 8'h0; e_din = 32'h0;
      due_now_vld = 1'b0; due_nxt_vld = 1'b0;
    end else begin
      check("csb0",   sram_csb0, e_csb);
      check("web0",   sram_web0, e_web);
      check("wmask0", sram_wmask0, e_wmask);
      check("addr0",  sram_addr0, e_addr);
      if (!e_csb && !e_web) check("din0", sram_din0, e_din);
      check("m0_rvalid", m0_rvalid, due_now_vld && !due_now_m1);
      check("m1_rvalid", m1_rvalid, due_now_vld && due_now_m1);
      if (due_now_vld) check("rdata", due_now_m1 ? m1_rdata : m0_rdata, due_now_dat);

      // Tie goes to whoever was not granted last, unless that master is mid-burst.
      hold = 1'b0;
`ifdef C0_SRAM_ARB_LOCK_EN
      hold = (m_run > 0) && (m_run < 4) &&
             (m_last_m1 ? (m1_req && m1_lock) : (m0_req && m0_lock));
`endif
      w1  = hold ? m_last_m1 : !m_last_m1;
      eg1 = m1_req && (!m0_req || w1);
      eg0 = m0_req && !eg1;
      check("m0_gnt", m0_gnt, eg0);
      check("m1_gnt", m1_gnt, eg1);

      due_now_vld = due_nxt_vld; due_now_m1 = due_nxt_m1; due_now_dat = due_nxt_dat;
      due_nxt_vld = 1'b0;
      if (eg0 || eg1) begin
        g_we   = eg1 ? m1_we    : m0_we;
        g_mask = eg1 ? m1_wmask : m0_wmask;
        g_addr = eg1 ? m1_addr  : m0_addr;
        g_wd   = eg1 ? m1_wdata : m0_wdata;
        if (g_we) begin
          for (int b = 0; b < 4; b++)
            if (g_mask[b]) ref_mem[g_addr][8*b +: 8] = g_wd[8*b +: 8];
        end else begin
          due_nxt_vld = 1'b1; due_nxt_m1 = eg1; due_nxt_dat = ref_mem[g_addr];
        end
        e_csb = 1'b0; e_web = !g_we; e_addr = g_addr; e_din = g_wd;
        e_wmask = g_we ? g_mask : 4'h0;
        if (eg1 ? m1_lock : m0_lock) m_run = (eg1 == m_last_m1 && m_run < 4) ? m_run + 1 : 1;
        else                         m_run = 0;
        m_last_m1 = eg1;
      end else begin
        e_csb = 1'b1; e_web = 1'b1; m_run = 0;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic next_cycle();
    @(posedge clk_g); #1;
  endtask

  task automatic idle();
    m0_req = 0; m1_req = 0; m0_lock = 0; m1_lock = 0;
  endtask

  task automatic drive(input bit m1, input bit we, input logic [7:0] a,
                       input logic [31:0] d, input logic [3:0] msk);
    if (m1) begin
      m1_req = 1; m1_we = we; m1_addr = a; m1_wdata = d; m1_wmask = msk;
    end else begin
      m0_req = 1; m0_we = we; m0_addr = a; m0_wdata = d; m0_wmask = msk;
    end
  endtask

  initial begin
    rst_g = 0;
    m0_we = 0; m0_wmask = 0; m0_addr = 0; m0_wdata = 0;
    m1_we = 0; m1_wmask = 0; m1_addr = 0; m1_wdata = 0;
    idle();
    repeat (3) next_cycle();
    rst_g = 1;

    // 1: idle for 20 cycles
    repeat (20) next_cycle();
    @(negedge clk_g);
    check("t1_idle_pins", {sram_csb0, sram_web0, m0_gnt, m1_gnt, m0_rvalid, m1_rvalid}, 6'b110000);

    // 2: m0 write then read of 0x10, response exactly two cycles after the read grant
    next_cycle();
    drive(0, 1, 8'h10, 32'hDEADBEEF, 4'hF);
    next_cycle();
    drive(0, 0, 8'h10, 32'h0, 4'hF);
    @(negedge clk_g);
    check("t2_rd_gnt", m0_gnt, 1'b1);
    next_cycle(); idle();
    @(negedge clk_g);
    check("t2_rvalid_n1", m0_rvalid, 1'b0);
    check("t2_rd_pins", {sram_csb0, sram_web0, sram_wmask0}, {1'b0, 1'b1, 4'h0});
    next_cycle();
    @(negedge clk_g);
    check("t2_rvalid_n2", m0_rvalid, 1'b1);
    check("t2_rdata", m0_rdata, 32'hDEADBEEF);
    repeat (2) next_cycle();

    // 4: partial write by m1 over all-ones
    drive(1, 1, 8'h20, 32'hFFFFFFFF, 4'hF);
    next_cycle();
    drive(1, 1, 8'h20, 32'h11223344, 4'h3);
    next_cycle();
    drive(1, 0, 8'h20, 32'h0, 4'h0);
    next_cycle(); idle();
    next_cycle();
    @(negedge clk_g);
    check("t4_rvalid", m1_rvalid, 1'b1);
    check("t4_rdata", m1_rdata, 32'hFFFF3344);
    repeat (2) next_cycle();

    // 3: both masters read continuously; grants alternate starting with m0
    drive(0, 0, 8'h10, 32'h0, 4'h0);
    drive(1, 0, 8'h20, 32'h0, 4'h0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk_g);
      check("t3_alt", {m0_gnt, m1_gnt}, (i % 2 == 0) ? 2'b10 : 2'b01);
      next_cycle();
    end
    idle();
    repeat (3) next_cycle();

    // 5: reset lands between accept and response
    drive(0, 0, 8'h10, 32'h0, 4'h0);
    @(negedge clk_g);
    check("t5_gnt", m0_gnt, 1'b1);
    next_cycle(); idle();
    #2 rst_g = 0;
    #1 check("t5_async_pins", {sram_csb0, sram_web0, sram_addr0}, {1'b1, 1'b1, 8'h0});
    next_cycle();
    rst_g = 1;
    repeat (2) begin
      @(negedge clk_g);
      check("t5_no_rvalid", {m0_rvalid, m1_rvalid}, 2'b00);
    end
    repeat (2) next_cycle();

`ifdef C0_SRAM_ARB_LOCK_EN
    // 6: m0 locked burst capped at four grants
    drive(0, 0, 8'h10, 32'h0, 4'h0);
    drive(1, 0, 8'h20, 32'h0, 4'h0);
    m0_lock = 1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk_g);
      check("t6_lock", {m0_gnt, m1_gnt}, (i == 4) ? 2'b01 : 2'b10);
      next_cycle();
    end
    idle();
    repeat (3) next_cycle();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
